// File: rtl/tl_cntr_nphase_pkg.sv
// Shared definitions for the N-phase traffic-light controller:
// light codes and FSM state encodings.
package tl_cntr_nphase_pkg;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

endpackage

// File: rtl/tl_cntr_nphase_phase_sel.sv
// Combinational next-phase picker: first phase with demand after cur in
// cyclic order (cur itself checked last), phase 0 when nobody is waiting.
module tl_phase_sel #(
    parameter int N_DIR = 2
) (
    input  logic [2:0]         cur,
    input  logic [2*N_DIR-1:0] demand,
    output logic [2:0]         nxt
);

    localparam int N_PH = 2 * N_DIR;

    logic found;

    // Constant-index compare avoids a variable bit-select wider than demand.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_PH; i++) begin
            for (int j = 0; j < N_PH; j++) begin
                if ((int'(cur) + i == j) || (int'(cur) + i == j + N_PH)) begin
                    if (!found && demand[j]) begin
                        nxt   = 3'(j);
                        found = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tl_cntr_nphase.sv
// N-approach traffic-light controller with straight and left-turn phases,
// demand-driven green extension and registered light outputs.
module tl_cntr_nphase
    import tl_cntr_nphase_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_DIR-1:0]   T,
    input  logic [N_DIR-1:0]   Tl,
    output logic [2*N_DIR-1:0] lt_s,
    output logic [2*N_DIR-1:0] lt_l,
    output logic [2:0]         phase,
    output logic               phase_start
);

    localparam int N_PH = 2 * N_DIR;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   timer, g_cnt;
    logic               timer_clr;
    logic               init_q;
    logic [2:0]         pend_phase, sel_phase, phase_nx;
    logic [N_PH-1:0]    demand;
    logic               cur_dem;
    logic [1:0]         code;
    logic [2*N_DIR-1:0] lt_s_nx, lt_l_nx;

    always_comb begin
        demand  = '0;
        cur_dem = 1'b0;
        for (int k = 0; k < N_DIR; k++) begin
            demand[2*k]   = T[k];
            demand[2*k+1] = Tl[k];
        end
        for (int i = 0; i < N_PH; i++) begin
            if (phase == 3'(i)) cur_dem = demand[i];
        end
    end

    tl_phase_sel #(.N_DIR(N_DIR)) u_sel (
        .cur    (phase),
        .demand (demand),
        .nxt    (sel_phase)
    );

    // init_q keeps the controller in ALLRED for the reset-release edge so the
    // clearance interval is counted only from the first edge out of reset.
    always_comb begin
        state_nx  = state;
        timer_clr = 1'b0;
        g_cnt     = timer + 1'b1;
        case (state)
            ST_ALLRED: begin
                if (init_q)
                    timer_clr = 1'b1;
                else if (timer == CNT_W'(ALLRED_T - 1))
                    state_nx = ST_GREEN;
            end
            ST_GREEN: begin
                if (g_cnt >= CNT_W'(GREEN_MIN) &&
                    (!cur_dem || g_cnt >= CNT_W'(GREEN_MAX)))
                    state_nx = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (timer == CNT_W'(YELLOW_T - 1))
                    state_nx = ST_ALLRED;
            end
            default: state_nx = ST_ALLRED;
        endcase
        if (state_nx != state) timer_clr = 1'b1;
    end

    always_comb begin
        phase_nx = (state == ST_ALLRED && state_nx == ST_GREEN) ? pend_phase : phase;
        code     = (state_nx == ST_GREEN) ? LT_GREEN : LT_YELLOW;
        lt_s_nx  = {N_DIR{LT_RED}};
        lt_l_nx  = {N_DIR{LT_RED}};
        if (state_nx != ST_ALLRED) begin
            for (int k = 0; k < N_DIR; k++) begin
                if (phase_nx == 3'(2*k))   lt_s_nx[2*k +: 2] = code;
                if (phase_nx == 3'(2*k+1)) lt_l_nx[2*k +: 2] = code;
            end
        end
    end

    // The chosen successor is latched in the last YELLOW cycle and held
    // through ALLRED, so sensor activity during clearance cannot redirect it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_ALLRED;
            timer       <= '0;
            init_q      <= 1'b1;
            pend_phase  <= '0;
            phase       <= '0;
            lt_s        <= {N_DIR{LT_RED}};
            lt_l        <= {N_DIR{LT_RED}};
            phase_start <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_clr ? '0 : timer + 1'b1;
            init_q      <= 1'b0;
            if (state == ST_YELLOW && state_nx == ST_ALLRED)
                pend_phase <= sel_phase;
            phase       <= phase_nx;
            lt_s        <= lt_s_nx;
            lt_l        <= lt_l_nx;
            phase_start <= (state == ST_ALLRED && state_nx == ST_GREEN);
        end
    end

endmodule

// File: tb/tb_tl_cntr_nphase.sv
// Directed bench for tl_cntr_nphase at default parameters: reset, demand
// skip, max green, no demand, wrap-around and reset during yellow.
module tb_tl_cntr_nphase;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] T, Tl;
    logic [3:0] lt_s, lt_l;
    logic [2:0] phase;
    logic       phase_start;

    int compared   = 0;
    int mismatched = 0;

    tl_cntr_nphase #(
        .N_DIR(2), .GREEN_MIN(4), .GREEN_MAX(10),
        .YELLOW_T(2), .ALLRED_T(1), .CNT_W(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .T           (T),
        .Tl          (Tl),
        .lt_s        (lt_s),
        .lt_l        (lt_l),
        .phase       (phase),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [1:0] tl);
        T  = t;
        Tl = tl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] light_of(input int p);
        case (p)
            0:       return lt_s[1:0];
            1:       return lt_l[1:0];
            2:       return lt_s[3:2];
            default: return lt_l[3:2];
        endcase
    endfunction

    function automatic logic [3:0] exp_s(input int p);
        case (p)
            0:       return 4'b0010;
            2:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] exp_l(input int p);
        case (p)
            1:       return 4'b0010;
            3:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Entered on the first GREEN cycle of phase cur; returns on the first
    // GREEN cycle of the following phase.
    task automatic checkSequence(input string tag, input int cur, input int g_exp, input int nxt);
        int n;
        checkOutput({tag, "_start"}, 32'(phase_start), 32'd1);
        checkOutput({tag, "_phase"}, 32'(phase), 32'(cur));
        checkOutput({tag, "_lt_s"}, 32'(lt_s), 32'(exp_s(cur)));
        checkOutput({tag, "_lt_l"}, 32'(lt_l), 32'(exp_l(cur)));
        n = 0;
        while (light_of(cur) == 2'b10 && n < 30) begin
            n++;
            tick(1);
        end
        checkOutput({tag, "_green_len"}, 32'(n), 32'(g_exp));
        checkOutput({tag, "_start_low"}, 32'(phase_start), 32'd0);
        checkOutput({tag, "_phase_held"}, 32'(phase), 32'(cur));
        n = 0;
        while (light_of(cur) == 2'b01 && n < 30) begin
            n++;
            tick(1);
        end
        checkOutput({tag, "_yellow_len"}, 32'(n), 32'd2);
        n = 0;
        while (lt_s == 4'b0000 && lt_l == 4'b0000 && n < 30) begin
            n++;
            tick(1);
        end
        checkOutput({tag, "_allred_len"}, 32'(n), 32'd1);
        checkOutput({tag, "_next_phase"}, 32'(phase), 32'(nxt));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        applyStimulus(2'b00, 2'b00);
        tick(2);
        checkOutput("rst_lt_s", 32'(lt_s), 32'h0);
        checkOutput("rst_lt_l", 32'(lt_l), 32'h0);
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_start", 32'(phase_start), 32'd0);

        reset_n = 1'b1;
        applyStimulus(2'b10, 2'b00);
        tick(1);
        checkOutput("rel_allred_s", 32'(lt_s), 32'h0);
        checkOutput("rel_allred_start", 32'(phase_start), 32'd0);
        tick(1);

        checkSequence("skip", 0, 4, 2);
        applyStimulus(2'b00, 2'b00);
        checkSequence("nodem", 2, 4, 0);
        applyStimulus(2'b11, 2'b01);
        checkSequence("maxg", 0, 10, 1);
        applyStimulus(2'b00, 2'b10);
        checkSequence("to3", 1, 4, 3);
        applyStimulus(2'b01, 2'b10);
        checkSequence("wrap", 3, 10, 0);

        checkOutput("myr_start", 32'(phase_start), 32'd1);
        checkOutput("myr_lt_s", 32'(lt_s), 32'h2);
        applyStimulus(2'b00, 2'b00);
        n = 0;
        while (light_of(0) == 2'b10 && n < 30) begin
            n++;
            tick(1);
        end
        checkOutput("myr_green_len", 32'(n), 32'd4);
        checkOutput("myr_yellow", 32'(light_of(0)), 32'h1);
        reset_n = 1'b0;
        tick(1);
        checkOutput("myr_rst_s", 32'(lt_s), 32'h0);
        checkOutput("myr_rst_l", 32'(lt_l), 32'h0);
        checkOutput("myr_rst_phase", 32'(phase), 32'd0);
        checkOutput("myr_rst_start", 32'(phase_start), 32'd0);
        reset_n = 1'b1;
        tick(1);
        checkOutput("myr_allred_s", 32'(lt_s), 32'h0);
        checkOutput("myr_allred_start", 32'(phase_start), 32'd0);
        tick(1);
        checkOutput("myr_green_s", 32'(lt_s), 32'h2);
        checkOutput("myr_green_phase", 32'(phase), 32'd0);
        checkOutput("myr_green_start", 32'(phase_start), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
